// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin values, coin indices and the
// change dispenser FSM state encoding.
package vm_pkg;

    localparam int CENTS_DOLLAR  = 100;
    localparam int CENTS_QUARTER = 25;
    localparam int CENTS_DIME    = 10;
    localparam int CENTS_NICKEL  = 5;

    typedef enum logic [2:0] {DOLLAR, QUARTER, DIME, NICKEL, NONE} coin_t;

    typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, FINISH} state_t;

    // Coin counters stick at 255 instead of wrapping.
    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request, hopper, eject and status signals of the change dispenser.
// req_valid/req_ready: a request transfers on a clock edge where both are high; req_amount is held stable while req_valid is high.
interface change_dispenser_if #(parameter int AMOUNT_W = 10);
    import vm_pkg::*;

    logic                req_valid;
    logic [AMOUNT_W-1:0] req_amount;
    logic                req_ready;
    logic                empty_dollar, empty_quarter, empty_dime, empty_nickel;
    logic                eject_dollar, eject_quarter, eject_dime, eject_nickel;
    logic                busy;
    logic                done;
    logic                rem_err;
    logic                short_err;
    logic [AMOUNT_W-1:0] short_amount;
    logic [7:0]          cnt_dollar, cnt_quarter, cnt_dime, cnt_nickel;
    state_t              dbgState;

    modport master (
        output req_valid, req_amount,
        output empty_dollar, empty_quarter, empty_dime, empty_nickel,
        input  req_ready, busy, done, rem_err, short_err, short_amount,
        input  eject_dollar, eject_quarter, eject_dime, eject_nickel,
        input  cnt_dollar, cnt_quarter, cnt_dime, cnt_nickel, dbgState
    );

    modport slave (
        input  req_valid, req_amount,
        input  empty_dollar, empty_quarter, empty_dime, empty_nickel,
        output req_ready, busy, done, rem_err, short_err, short_amount,
        output eject_dollar, eject_quarter, eject_dime, eject_nickel,
        output cnt_dollar, cnt_quarter, cnt_dime, cnt_nickel, dbgState
    );

endinterface

// File: rtl/change_dispenser_coin_pick.sv
// Greedy coin choice: the largest non-empty denomination not exceeding
// the remaining amount, or NONE when nothing fits.
module coin_pick
    import vm_pkg::*;
#(
    parameter int AMOUNT_W = 10
) (
    input  logic [AMOUNT_W-1:0] remaining,
    input  logic                emptyDollar,
    input  logic                emptyQuarter,
    input  logic                emptyDime,
    input  logic                emptyNickel,
    output coin_t               coin,
    output logic [AMOUNT_W-1:0] value
);

    always_comb begin
        coin  = NONE;
        value = '0;
        if (!emptyDollar && remaining >= AMOUNT_W'(CENTS_DOLLAR)) begin
            coin  = DOLLAR;
            value = AMOUNT_W'(CENTS_DOLLAR);
        end else if (!emptyQuarter && remaining >= AMOUNT_W'(CENTS_QUARTER)) begin
            coin  = QUARTER;
            value = AMOUNT_W'(CENTS_QUARTER);
        end else if (!emptyDime && remaining >= AMOUNT_W'(CENTS_DIME)) begin
            coin  = DIME;
            value = AMOUNT_W'(CENTS_DIME);
        end else if (!emptyNickel && remaining >= AMOUNT_W'(CENTS_NICKEL)) begin
            coin  = NICKEL;
            value = AMOUNT_W'(CENTS_NICKEL);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a requested amount as a sequence of timed coin
// eject pulses, largest coin first, skipping empty hoppers.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int AMOUNT_W     = 10,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input logic               clk,
    input logic               rst_n,
    change_dispenser_if.slave bus
);

    state_t              stateQ, stateD;
    logic [AMOUNT_W-1:0] remaining;
    logic [AMOUNT_W-1:0] residue;
    coin_t               selCoin;
    logic [15:0]         timer;
    logic [7:0]          cntDollar, cntQuarter, cntDime, cntNickel;
    logic                remErr, shortErr;
    logic [AMOUNT_W-1:0] shortAmount;
    coin_t               pickCoin;
    logic [AMOUNT_W-1:0] pickValue;

    assign residue = bus.req_amount % AMOUNT_W'(5);

    coin_pick #(.AMOUNT_W(AMOUNT_W)) uPick (
        .remaining    (remaining),
        .emptyDollar  (bus.empty_dollar),
        .emptyQuarter (bus.empty_quarter),
        .emptyDime    (bus.empty_dime),
        .emptyNickel  (bus.empty_nickel),
        .coin         (pickCoin),
        .value        (pickValue)
    );

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE:    if (bus.req_valid) stateD = SELECT;
            SELECT:  stateD = (remaining == '0 || pickCoin == NONE) ? FINISH : PULSE;
            PULSE:   if (timer == 16'(PULSE_CYCLES - 1)) stateD = GAP;
            GAP:     if (timer == 16'(GAP_CYCLES - 1)) stateD = SELECT;
            FINISH:  stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ      <= IDLE;
            remaining   <= '0;
            selCoin     <= NONE;
            timer       <= '0;
            cntDollar   <= '0;
            cntQuarter  <= '0;
            cntDime     <= '0;
            cntNickel   <= '0;
            remErr      <= 1'b0;
            shortErr    <= 1'b0;
            shortAmount <= '0;
        end else begin
            stateQ <= stateD;
            // The timer restarts on every state change so PULSE and GAP each count from zero.
            timer  <= (stateD != stateQ) ? '0 : timer + 16'd1;
            if (stateQ == IDLE && bus.req_valid) begin
                remaining   <= bus.req_amount - residue;
                remErr      <= (residue != '0);
                shortErr    <= 1'b0;
                shortAmount <= '0;
                cntDollar   <= '0;
                cntQuarter  <= '0;
                cntDime     <= '0;
                cntNickel   <= '0;
            end else if (stateQ == SELECT && remaining != '0) begin
                if (pickCoin == NONE) begin
                    shortErr    <= 1'b1;
                    shortAmount <= remaining;
                end else begin
                    remaining <= remaining - pickValue;
                    selCoin   <= pickCoin;
                    unique case (pickCoin)
                        DOLLAR:  cntDollar  <= satInc(cntDollar);
                        QUARTER: cntQuarter <= satInc(cntQuarter);
                        DIME:    cntDime    <= satInc(cntDime);
                        default: cntNickel  <= satInc(cntNickel);
                    endcase
                end
            end
        end
    end

    // Ejects decode straight from state so an asynchronous reset drops them at once.
    assign bus.eject_dollar  = (stateQ == PULSE) && (selCoin == DOLLAR);
    assign bus.eject_quarter = (stateQ == PULSE) && (selCoin == QUARTER);
    assign bus.eject_dime    = (stateQ == PULSE) && (selCoin == DIME);
    assign bus.eject_nickel  = (stateQ == PULSE) && (selCoin == NICKEL);

    assign bus.req_ready    = (stateQ == IDLE);
    assign bus.busy         = (stateQ != IDLE);
    assign bus.done         = (stateQ == FINISH);
    assign bus.rem_err      = remErr;
    assign bus.short_err    = shortErr;
    assign bus.short_amount = shortAmount;
    assign bus.cnt_dollar   = cntDollar;
    assign bus.cnt_quarter  = cntQuarter;
    assign bus.cnt_dime     = cntDime;
    assign bus.cnt_nickel   = cntNickel;
    assign bus.dbgState     = stateQ;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a transaction-level model expands each
// request into a per-cycle expected output trace plus final counts and flags.
module tb_change_dispenser;

    localparam int AMOUNT_W = 10;
    localparam int PULSE    = 4;
    localparam int GAP      = 4;

    logic clk;
    logic rst_n;

    change_dispenser_if #(.AMOUNT_W(AMOUNT_W)) bus ();

    change_dispenser #(
        .AMOUNT_W     (AMOUNT_W),
        .PULSE_CYCLES (PULSE),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle vector: {req_ready, busy, done, ej_dollar, ej_quarter, ej_dime, ej_nickel}
    logic [6:0] exp_q[$];
    logic       checkEn = 1'b1;
    int         popCnt;
    int         doneCyc;
    int         firstEj;

    int         mCnt[4];
    logic       mRemErr;
    logic       mShort;
    int         mShortAmt;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Greedy payout from the coin rules; timing from the per-coin cost of
    // one SELECT + PULSE + GAP cycles, then a final SELECT and FINISH.
    task automatic runModel(input int amount, input logic [3:0] empt);
        int vals[4];
        int rem;
        int pick;
        vals = '{100, 25, 10, 5};
        for (int i = 0; i < 4; i++) mCnt[i] = 0;
        mRemErr   = (amount % 5) != 0;
        rem       = amount - (amount % 5);
        mShort    = 1'b0;
        mShortAmt = 0;
        while (rem > 0) begin
            pick = -1;
            for (int i = 0; i < 4; i++)
                if (pick < 0 && !empt[3-i] && vals[i] <= rem) pick = i;
            if (pick < 0) begin
                mShort    = 1'b1;
                mShortAmt = rem;
                break;
            end
            rem -= vals[pick];
            mCnt[pick]++;
            exp_q.push_back(7'b0100000);
            repeat (PULSE) exp_q.push_back({3'b010, 4'b1000 >> pick});
            repeat (GAP) exp_q.push_back(7'b0100000);
        end
        exp_q.push_back(7'b0100000);
        exp_q.push_back(7'b0110000);
        exp_q.push_back(7'b1000000);
    endtask

    always @(negedge clk) begin
        logic [6:0] e;
        logic [6:0] a;
        if (checkEn && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            popCnt++;
            a = {bus.req_ready, bus.busy, bus.done, bus.eject_dollar,
                 bus.eject_quarter, bus.eject_dime, bus.eject_nickel};
            if (a[4] && doneCyc < 0) doneCyc = popCnt;
            if ((|a[3:0]) && firstEj < 0) firstEj = popCnt;
            chk("cycle_outputs", int'(a), int'(e));
        end
    end

    task automatic accept(input int amount, input logic [3:0] empt);
        @(negedge clk);
        {bus.empty_dollar, bus.empty_quarter, bus.empty_dime, bus.empty_nickel} = empt;
        bus.req_amount = AMOUNT_W'(amount);
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        popCnt  = 0;
        doneCyc = -1;
        firstEj = -1;
        runModel(amount, empt);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic checkResult();
        chk("cnt_dollar", int'(bus.cnt_dollar), mCnt[0]);
        chk("cnt_quarter", int'(bus.cnt_quarter), mCnt[1]);
        chk("cnt_dime", int'(bus.cnt_dime), mCnt[2]);
        chk("cnt_nickel", int'(bus.cnt_nickel), mCnt[3]);
        chk("rem_err", int'(bus.rem_err), int'(mRemErr));
        chk("short_err", int'(bus.short_err), int'(mShort));
        chk("short_amount", int'(bus.short_amount), mShortAmt);
    endtask

    task automatic doReq(input int amount, input logic [3:0] empt, input bit pokeBusy);
        accept(amount, empt);
        if (pokeBusy) begin
            repeat (3) @(negedge clk);
            bus.req_valid  = 1'b1;
            bus.req_amount = AMOUNT_W'($urandom_range(1, 1023));
            repeat (4) @(negedge clk);
            bus.req_valid = 1'b0;
        end
        waitDrain();
        checkResult();
    endtask

    task automatic checkResetState(input string tag);
        chk({tag, "_req_ready"}, int'(bus.req_ready), 1);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_ejects"}, int'({bus.eject_dollar, bus.eject_quarter, bus.eject_dime, bus.eject_nickel}), 0);
        chk({tag, "_counts"}, int'({bus.cnt_dollar, bus.cnt_quarter, bus.cnt_dime, bus.cnt_nickel}), 0);
        chk({tag, "_errs"}, int'({bus.rem_err, bus.short_err}), 0);
        chk({tag, "_short_amount"}, int'(bus.short_amount), 0);
    endtask

    initial begin
        int n;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_amount = '0;
        {bus.empty_dollar, bus.empty_quarter, bus.empty_dime, bus.empty_nickel} = 4'b0000;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 140, all full: one of each coin, first eject at T+2, done at T+38
        doReq(140, 4'b0000, 1'b0);
        chk("t1_first_eject_cycle", firstEj, 2);
        chk("t1_done_cycle", doneCyc, 38);
        chk("t1_cnt_all", int'({bus.cnt_dollar, bus.cnt_quarter, bus.cnt_dime, bus.cnt_nickel}), 32'h01010101);

        // 65 with quarters empty: six dimes then a nickel
        doReq(65, 4'b0100, 1'b0);
        chk("t2_cnt_dime", int'(bus.cnt_dime), 6);
        chk("t2_cnt_nickel", int'(bus.cnt_nickel), 1);
        chk("t2_cnt_quarter", int'(bus.cnt_quarter), 0);

        // zero amount: done two cycles after accept, nothing ejected
        doReq(0, 4'b0000, 1'b0);
        chk("t3_done_cycle", doneCyc, 2);
        chk("t3_no_eject", firstEj, -1);

        // 37 with a busy-time request poke: residue flagged, quarter+dime paid
        doReq(37, 4'b0000, 1'b1);
        chk("t4_rem_err", int'(bus.rem_err), 1);

        // 30 with dimes and nickels empty: a quarter, then 5 cents short
        doReq(30, 4'b0011, 1'b0);
        chk("t5_short_amount", int'(bus.short_amount), 5);
        chk("t5_short_err", int'(bus.short_err), 1);

        // a large amount exercising several dollars
        doReq(1023, 4'b0000, 1'b0);

        // reset asserted in the middle of a quarter pulse
        accept(25, 4'b0000);
        n = 0;
        while (!bus.eject_quarter && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t6_quarter_seen", int'(bus.eject_quarter), 1);
        checkEn = 1'b0;
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("midpulse_reset");
        @(negedge clk);
        rst_n   = 1'b1;
        checkEn = 1'b1;

        doReq(25, 4'b0000, 1'b0);
        chk("t6_after_reset_quarter", int'(bus.cnt_quarter), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
